if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the pipelined RV32 core.
- Owns the PC, addresses the synchronous instruction memory and handles stall and branch redirect.
- Presents a registered instruction, PC and valid bit to decode; INSTRUCTION_ID feeds IMM_GEN and the control decoder directly.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013 (addi x0,x0,0), instruction driven to decode when the slot is a bubble.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- STALL  in  1  hazard-unit hold request; freezes PC and IF/ID.
- REDIRECT  in  1  taken branch/jump from EX; flushes in-flight fetches.
- REDIRECT_PC  in  32  redirect target; bits [1:0] are ignored (forced to 0).
- IMEM_ADDR  out  32  instruction memory byte address; equals the PC register.
- IMEM_EN  out  1  memory read enable.
- IMEM_RDATA  in  32  memory read data. Valid one cycle after an enabled read. Held while IMEM_EN=0.
- INSTRUCTION_ID  out  32  registered instruction to decode.
- PC_ID  out  32  byte address of INSTRUCTION_ID.
- VALID_ID  out  1  1 = INSTRUCTION_ID is a real instruction; 0 = bubble.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; ports are CLK and RST.
- Internal state:
  - pc_f (32): current fetch address.
  - req_valid (1) and req_pc (32): the read issued last cycle.
- Combinational outputs: IMEM_ADDR = pc_f; IMEM_EN = !STALL && !RST.
- Per-edge update, in priority order:
  1. RST: pc_f<=RESET_PC; req_valid<=0; req_pc<=0; VALID_ID<=0; INSTRUCTION_ID<=NOP_INSTR; PC_ID<=0. Reset mid-stream discards all in-flight fetches.
  2. REDIRECT (wins over STALL): pc_f<={REDIRECT_PC[31:2],2'b00}; req_valid<=0; VALID_ID<=0; INSTRUCTION_ID<=NOP_INSTR; PC_ID unchanged. The read in flight is squashed.
  3. STALL: pc_f, req_valid, req_pc, INSTRUCTION_ID, PC_ID and VALID_ID all hold. Memory output holds, so no data is lost.
  4. Otherwise (advance): pc_f<=pc_f+4; req_valid<=1; req_pc<=pc_f; INSTRUCTION_ID<= req_valid ? IMEM_RDATA : NOP_INSTR; PC_ID<=req_pc; VALID_ID<=req_valid.
- Latency:
  - After RST falls, the first valid instruction appears at the second rising edge. It is mem[RESET_PC] with PC_ID=RESET_PC.
  - After the edge that samples REDIRECT, VALID_ID is 0 for 2 cycles. It then shows mem[target] with PC_ID=target, assuming no stall.
- Steady state: one instruction per cycle, with PC_ID incrementing by 4.
- Wrap-around: pc_f=32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- STALL held for N cycles: outputs are frozen for exactly N cycles. The instruction sequence resumes with no duplicate and no skip.
- REDIRECT while STALL: the redirect is taken that edge. The stall only suppresses IMEM_EN that cycle.
- Back-to-back REDIRECT: each one restarts the 2-bubble sequence; the last target wins.
- No X may propagate to VALID_ID. INSTRUCTION_ID is NOP_INSTR whenever VALID_ID=0 after reset or a flush.

Test Plan:
- Reset release: mem[0]=32'h0050_0093, mem[4]=32'h0010_0113. RST 1→0. Required: 2nd edge VALID_ID=1, INSTRUCTION_ID=32'h0050_0093, PC_ID=0. Next edge INSTRUCTION_ID=32'h0010_0113, PC_ID=4.
- Streaming: run 8 cycles from reset. Required: PC_ID = 0,4,8,…,28 on consecutive cycles, VALID_ID held at 1, INSTRUCTION_ID matching memory.
- Stall: assert STALL for 3 cycles while PC_ID=8. Required: outputs frozen at PC_ID=8 for 3 cycles; IMEM_EN=0 during the stall; then PC_ID=12 with no gap or repeat.
- Redirect: REDIRECT=1 with REDIRECT_PC=32'h0000_0103 while PC_ID=16. Required: 2 cycles of VALID_ID=0 and INSTRUCTION_ID=32'h0000_0013; then PC_ID=32'h0000_0100 with VALID_ID=1, then 0x104.
- Redirect plus stall in the same cycle, then STALL held 2 more cycles. Required: redirect taken, VALID_ID=0 throughout the stall. After release, first valid PC_ID is the target, 2 cycles later.
- Wrap and mid-stream reset:
  - Redirect to 32'hFFFF_FFF8. Required: PC_ID shows FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - Then pulse RST for 1 cycle. Required: VALID_ID=0 next edge, and the sequence restarts at RESET_PC.

Source files
------------

// File: rtl/if_id_stage_if.sv
// Fetch-stage signal bundle: hazard/redirect controls, instruction memory port
// and the IF/ID register outputs that feed decode.
interface if_id_stage_if;
  logic        STALL;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_EN;
  logic [31:0] IMEM_RDATA;
  logic [31:0] INSTRUCTION_ID;
  logic [31:0] PC_ID;
  logic        VALID_ID;

  // Fetch stage side
  modport slave (
    input  STALL, REDIRECT, REDIRECT_PC, IMEM_RDATA,
    output IMEM_ADDR, IMEM_EN, INSTRUCTION_ID, PC_ID, VALID_ID
  );

  // Environment side: hazard unit, EX redirect, instruction memory, decode
  modport master (
    output STALL, REDIRECT, REDIRECT_PC, IMEM_RDATA,
    input  IMEM_ADDR, IMEM_EN, INSTRUCTION_ID, PC_ID, VALID_ID
  );
endinterface

// File: rtl/if_id_stage.sv
// RV32 instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, drives the synchronous instruction memory, handles stall and redirect.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          CLK,
  input  logic          RST,
  if_id_stage_if.slave  bus
);

  localparam logic [1:0] ACT_REDIRECT = 2'd0;
  localparam logic [1:0] ACT_HOLD     = 2'd1;
  localparam logic [1:0] ACT_ADVANCE  = 2'd2;

  // Word-align a target address; low two bits are never honoured.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    align_word = {addr[31:2], 2'b00};
  endfunction

  // Sequential next PC; wraps silently at the top of the address space.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    next_pc = pc + 32'd4;
  endfunction

  logic [31:0] r_pc_f;
  logic        r_req_valid;
  logic [31:0] r_req_pc;
  logic [31:0] r_instr_id;
  logic [31:0] r_pc_id;
  logic        r_valid_id;

  logic [1:0]  w_act;
  logic [31:0] w_pc_f_nxt;
  logic        w_req_valid_nxt;
  logic [31:0] w_req_pc_nxt;
  logic [31:0] w_instr_id_nxt;
  logic [31:0] w_pc_id_nxt;
  logic        w_valid_id_nxt;

  // Redirect outranks stall: a taken branch must never be delayed by a hazard hold.
  always_comb begin
    w_act = ACT_ADVANCE;
    if (bus.REDIRECT) begin
      w_act = ACT_REDIRECT;
    end else if (bus.STALL) begin
      w_act = ACT_HOLD;
    end else begin
      w_act = ACT_ADVANCE;
    end
  end

  // Next-state selection for the PC, the outstanding-read tracker and IF/ID.
  always_comb begin
    w_pc_f_nxt      = r_pc_f;
    w_req_valid_nxt = r_req_valid;
    w_req_pc_nxt    = r_req_pc;
    w_instr_id_nxt  = r_instr_id;
    w_pc_id_nxt     = r_pc_id;
    w_valid_id_nxt  = r_valid_id;
    case (w_act)
      ACT_REDIRECT: begin
        w_pc_f_nxt      = align_word(bus.REDIRECT_PC);
        w_req_valid_nxt = 1'b0;
        w_instr_id_nxt  = NOP_INSTR;
        w_valid_id_nxt  = 1'b0;
      end
      ACT_HOLD: begin
        // Memory output is held while disabled, so freezing here loses nothing.
        w_pc_f_nxt      = r_pc_f;
        w_req_valid_nxt = r_req_valid;
      end
      ACT_ADVANCE: begin
        w_pc_f_nxt      = next_pc(r_pc_f);
        w_req_valid_nxt = 1'b1;
        w_req_pc_nxt    = r_pc_f;
        w_instr_id_nxt  = r_req_valid ? bus.IMEM_RDATA : NOP_INSTR;
        w_pc_id_nxt     = r_req_pc;
        w_valid_id_nxt  = r_req_valid;
      end
      default: begin
        w_req_valid_nxt = 1'b0;
        w_instr_id_nxt  = NOP_INSTR;
        w_valid_id_nxt  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any in-flight fetch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc_f      <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_pc    <= 32'h0000_0000;
      r_instr_id  <= NOP_INSTR;
      r_pc_id     <= 32'h0000_0000;
      r_valid_id  <= 1'b0;
    end else begin
      r_pc_f      <= w_pc_f_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_req_pc    <= w_req_pc_nxt;
      r_instr_id  <= w_instr_id_nxt;
      r_pc_id     <= w_pc_id_nxt;
      r_valid_id  <= w_valid_id_nxt;
    end
  end

  assign bus.IMEM_ADDR      = r_pc_f;
  assign bus.IMEM_EN        = !bus.STALL && !RST;
  assign bus.INSTRUCTION_ID = r_instr_id;
  assign bus.PC_ID          = r_pc_id;
  assign bus.VALID_ID       = r_valid_id;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset release, streaming, stall, redirect,
// redirect under stall, back-to-back redirect, wrap-around and mid-stream reset.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic CLK;
  logic RST;
  int   n_vec;
  int   n_err;

  if_id_stage_if bus ();

  if_id_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory contents: two fixed words at 0 and 4, an address-derived pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0050_0093;
      32'h0000_0004: mem_word = 32'h0010_0113;
      default:       mem_word = {a[15:0] ^ 16'hC3C3, a[17:2]};
    endcase
  endfunction

  // Synchronous instruction memory: data one cycle after an enabled read, held otherwise.
  always @(posedge CLK) begin
    if (bus.IMEM_EN) bus.IMEM_RDATA <= mem_word(bus.IMEM_ADDR);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_bubble(input string tag);
    check({tag, ".valid"}, {31'd0, bus.VALID_ID}, 32'd0);
    check({tag, ".instr"}, bus.INSTRUCTION_ID, NOP);
  endtask

  task automatic expect_instr(input string tag, input logic [31:0] pc);
    check({tag, ".valid"}, {31'd0, bus.VALID_ID}, 32'd1);
    check({tag, ".pc"},    bus.PC_ID, pc);
    check({tag, ".instr"}, bus.INSTRUCTION_ID, mem_word(pc));
  endtask

  // Release reset and step to the first valid instruction (PC_ID = 0).
  task automatic restart(input string tag);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    expect_bubble({tag, ".e1"});
    tick();
    expect_instr({tag, ".e2"}, 32'h0000_0000);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    RST = 1'b1;
    bus.STALL = 1'b0;
    bus.REDIRECT = 1'b0;
    bus.REDIRECT_PC = 32'h0000_0000;

    // Reset state
    tick();
    tick();
    expect_bubble("rst");
    check("rst.pc_id", bus.PC_ID, 32'h0000_0000);
    check("rst.addr", bus.IMEM_ADDR, 32'h0000_0000);
    check("rst.en", {31'd0, bus.IMEM_EN}, 32'd0);

    // Reset release and streaming 0..28
    RST = 1'b0;
    #1;
    check("rel.en", {31'd0, bus.IMEM_EN}, 32'd1);
    tick();
    expect_bubble("rel.e1");
    tick();
    check("rel.e2.instr", bus.INSTRUCTION_ID, 32'h0050_0093);
    expect_instr("rel.e2", 32'h0000_0000);
    tick();
    check("rel.e3.instr", bus.INSTRUCTION_ID, 32'h0010_0113);
    for (int i = 2; i < 8; i++) begin
      tick();
      expect_instr("stream", 32'(i * 4));
    end

    // Stall three cycles while PC_ID = 8
    restart("rs1");
    tick();
    tick();
    expect_instr("pre_stall", 32'h0000_0008);
    bus.STALL = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("stall.en", {31'd0, bus.IMEM_EN}, 32'd0);
      tick();
      expect_instr("stall", 32'h0000_0008);
    end
    bus.STALL = 1'b0;
    tick();
    expect_instr("post_stall", 32'h0000_000C);
    tick();
    expect_instr("pre_redir", 32'h0000_0010);

    // Redirect to 0x103 (aligned to 0x100)
    bus.REDIRECT = 1'b1;
    bus.REDIRECT_PC = 32'h0000_0103;
    tick();
    bus.REDIRECT = 1'b0;
    expect_bubble("redir.b1");
    check("redir.b1.pc", bus.PC_ID, 32'h0000_0010);
    check("redir.addr", bus.IMEM_ADDR, 32'h0000_0100);
    tick();
    expect_bubble("redir.b2");
    tick();
    expect_instr("redir.t", 32'h0000_0100);
    tick();
    expect_instr("redir.t4", 32'h0000_0104);

    // Redirect and stall together, stall held two more cycles
    bus.REDIRECT = 1'b1;
    bus.STALL = 1'b1;
    bus.REDIRECT_PC = 32'h0000_0200;
    #1;
    check("rs.en", {31'd0, bus.IMEM_EN}, 32'd0);
    tick();
    bus.REDIRECT = 1'b0;
    expect_bubble("rs.s0");
    check("rs.addr", bus.IMEM_ADDR, 32'h0000_0200);
    for (int i = 0; i < 2; i++) begin
      tick();
      expect_bubble("rs.hold");
    end
    bus.STALL = 1'b0;
    tick();
    expect_bubble("rs.b1");
    tick();
    expect_instr("rs.t", 32'h0000_0200);

    // Back-to-back redirects: last target wins
    bus.REDIRECT = 1'b1;
    bus.REDIRECT_PC = 32'h0000_0300;
    tick();
    bus.REDIRECT_PC = 32'h0000_0400;
    tick();
    bus.REDIRECT = 1'b0;
    expect_bubble("b2b.r2");
    tick();
    expect_bubble("b2b.b1");
    tick();
    expect_instr("b2b.t", 32'h0000_0400);

    // Wrap-around
    bus.REDIRECT = 1'b1;
    bus.REDIRECT_PC = 32'hFFFF_FFF8;
    tick();
    bus.REDIRECT = 1'b0;
    tick();
    tick();
    expect_instr("wrap.0", 32'hFFFF_FFF8);
    tick();
    expect_instr("wrap.1", 32'hFFFF_FFFC);
    tick();
    expect_instr("wrap.2", 32'h0000_0000);

    // Mid-stream reset pulse
    RST = 1'b1;
    #1;
    check("mrst.en", {31'd0, bus.IMEM_EN}, 32'd0);
    tick();
    RST = 1'b0;
    expect_bubble("mrst.e0");
    check("mrst.pc_id", bus.PC_ID, 32'h0000_0000);
    check("mrst.addr", bus.IMEM_ADDR, 32'h0000_0000);
    tick();
    expect_bubble("mrst.e1");
    tick();
    expect_instr("mrst.e2", 32'h0000_0000);
    tick();
    expect_instr("mrst.e3", 32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
